// File: rtl/prewish5k_mask_scheduler_if.sv
// Command and mentor-load bus of the mask scheduler.
// The scheduler side uses the slave modport; the controller/mentor side uses master.
interface prewish5k_mask_scheduler_if #(
    parameter int unsigned SLOT_BITS = 2
);
    logic                 STB_I;
    logic [1:0]           CMD_I;
    logic [SLOT_BITS-1:0] ADR_I;
    logic [7:0]           DAT_I;
    logic                 ACK_O;
    logic                 STB_O;
    logic [7:0]           DAT_O;

    modport slave (
        input  STB_I, CMD_I, ADR_I, DAT_I,
        output ACK_O, STB_O, DAT_O
    );

    modport master (
        output STB_I, CMD_I, ADR_I, DAT_I,
        input  ACK_O, STB_O, DAT_O
    );
endinterface

// File: rtl/prewish5k_mask_scheduler.sv
// Mask playlist scheduler: holds a table of blink masks and replays them to the mentor
// as one-cycle strobes, in slot order, spaced by a programmable dwell period.
module prewish5k_mask_scheduler #(
    parameter int unsigned SLOT_BITS     = 2,
    parameter int unsigned DWELL_BITS    = 24,
    parameter int unsigned DEFAULT_DWELL = 12000000,
    parameter int unsigned ALIVE_BITS    = 22
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    prewish5k_mask_scheduler_if.slave     bus,
    output logic                          o_running,
    output logic [SLOT_BITS-1:0]          o_slot,
    output logic                          o_alive
);
    localparam int unsigned DEPTH = 2 ** SLOT_BITS;
    localparam logic [1:0] CMD_WRITE = 2'b00;
    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_STOP  = 2'b10;
    localparam logic [1:0] CMD_DWELL = 2'b11;

    typedef enum logic [1:0] {StIdle, StEmit, StDwell} state_e;

    state_e                r_state;
    logic [7:0]            r_table [DEPTH];
    logic [DWELL_BITS-1:0] r_reload;
    logic [DWELL_BITS-1:0] r_cnt;
    logic [SLOT_BITS-1:0]  r_slot;
    logic [SLOT_BITS-1:0]  r_last;
    logic [SLOT_BITS-1:0]  r_oslot;
    logic [ALIVE_BITS-1:0] r_alive;
    logic                  r_ack;
    logic                  r_stb;
    logic [7:0]            r_dat;
    logic                  r_running;

    logic                  w_write;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_dwell;
    logic [7:0]            w_coarse;
    logic [DWELL_BITS-1:0] w_dwell_val;
    logic [SLOT_BITS-1:0]  w_slot_next;

    assign w_write     = bus.STB_I && (bus.CMD_I == CMD_WRITE);
    assign w_start     = bus.STB_I && (bus.CMD_I == CMD_START);
    assign w_stop      = bus.STB_I && (bus.CMD_I == CMD_STOP);
    assign w_dwell     = bus.STB_I && (bus.CMD_I == CMD_DWELL);
    // A zero coarse value would stall the sequence, so it is promoted to 1.
    assign w_coarse    = (bus.DAT_I == 8'd0) ? 8'd1 : bus.DAT_I;
    assign w_dwell_val = {w_coarse, {(DWELL_BITS - 8){1'b0}}};
    assign w_slot_next = (r_slot == r_last) ? '0 : r_slot + SLOT_BITS'(1);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state   <= StIdle;
            r_reload  <= DWELL_BITS'(DEFAULT_DWELL);
            r_cnt     <= '0;
            r_slot    <= '0;
            r_last    <= '0;
            r_oslot   <= '0;
            r_alive   <= '0;
            r_ack     <= 1'b0;
            r_stb     <= 1'b0;
            r_dat     <= 8'd0;
            r_running <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= 8'd0;
            end
        end else begin
            r_ack   <= bus.STB_I;
            r_stb   <= 1'b0;
            r_alive <= r_alive + ALIVE_BITS'(1);
            // START/STOP take priority over whatever the sequencer had pending.
            if (w_start) begin
                r_last    <= bus.ADR_I;
                r_slot    <= '0;
                r_running <= 1'b1;
                r_state   <= StEmit;
            end else if (w_stop) begin
                r_running <= 1'b0;
                r_state   <= StIdle;
            end else begin
                unique case (r_state)
                    StEmit: begin
                        r_stb   <= 1'b1;
                        r_dat   <= r_table[r_slot];
                        r_oslot <= r_slot;
                        if (r_reload == DWELL_BITS'(1)) begin
                            r_slot <= w_slot_next;
                        end else begin
                            // EMIT and the expiry cycle account for two clocks of the period.
                            r_cnt   <= r_reload - DWELL_BITS'(2);
                            r_state <= StDwell;
                        end
                    end
                    StDwell: begin
                        if (r_cnt == '0) begin
                            r_slot  <= w_slot_next;
                            r_state <= StEmit;
                        end else begin
                            r_cnt <= r_cnt - DWELL_BITS'(1);
                        end
                    end
                    default: ;
                endcase
            end
            if (w_write) begin
                r_table[bus.ADR_I] <= bus.DAT_I;
            end
            if (w_dwell) begin
                r_reload <= w_dwell_val;
            end
        end
    end

    assign bus.ACK_O = r_ack;
    assign bus.STB_O = r_stb;
    assign bus.DAT_O = r_dat;
    assign o_running = r_running;
    assign o_slot    = r_oslot;
    assign o_alive   = r_alive[ALIVE_BITS-1];
endmodule

// File: tb/tb_prewish5k_mask_scheduler.sv
// Bench for the mask scheduler: directed scenarios plus random commands, checked every
// cycle against a timeline model that schedules strobes by absolute clock index.
module tb_prewish5k_mask_scheduler;
    localparam int unsigned SLOT_BITS     = 2;
    localparam int unsigned DWELL_BITS    = 10;
    localparam int unsigned DEFAULT_DWELL = 20;
    localparam int unsigned ALIVE_BITS    = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 o_running;
    logic [SLOT_BITS-1:0] o_slot;
    logic                 o_alive;

    prewish5k_mask_scheduler_if #(.SLOT_BITS(SLOT_BITS)) bus ();

    prewish5k_mask_scheduler #(
        .SLOT_BITS    (SLOT_BITS),
        .DWELL_BITS   (DWELL_BITS),
        .DEFAULT_DWELL(DEFAULT_DWELL),
        .ALIVE_BITS   (ALIVE_BITS)
    ) dut (
        .CLK_I    (clk),
        .RST_I    (rst),
        .bus      (bus),
        .o_running(o_running),
        .o_slot   (o_slot),
        .o_alive  (o_alive)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: next strobe is scheduled at an absolute edge index.
    logic [7:0]            m_table [4];
    int                    m_reload;
    int                    m_last;
    bit                    m_running;
    int                    m_next_t;
    int                    m_slot;
    logic                  m_ack;
    logic                  m_stb;
    logic [7:0]            m_dat;
    logic [SLOT_BITS-1:0]  m_oslot;
    logic [ALIVE_BITS-1:0] m_alive;
    int                    e = 0;

    int                    stb_t[$];
    logic [7:0]            stb_d[$];
    logic [SLOT_BITS-1:0]  stb_s[$];

    logic [7:0] exp_basic [5];
    logic [7:0] exp_short [4];
    logic [7:0] saved_dat;
    int         k;
    int         p;
    bit         found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        e++;
        if (rst) begin
            m_reload  = DEFAULT_DWELL;
            m_running = 1'b0;
            m_last    = 0;
            m_slot    = 0;
            m_next_t  = 0;
            m_ack     = 1'b0;
            m_stb     = 1'b0;
            m_dat     = 8'd0;
            m_oslot   = '0;
            m_alive   = '0;
            for (int i = 0; i < 4; i++) m_table[i] = 8'd0;
        end else begin
            m_ack = bus.STB_I;
            m_stb = 1'b0;
            m_alive++;
            if (bus.STB_I && bus.CMD_I == 2'd1) begin
                m_running = 1'b1;
                m_last    = int'(bus.ADR_I);
                m_slot    = 0;
                m_next_t  = e + 1;
            end else if (bus.STB_I && bus.CMD_I == 2'd2) begin
                m_running = 1'b0;
            end else if (m_running && e == m_next_t) begin
                m_stb    = 1'b1;
                m_dat    = m_table[m_slot];
                m_oslot  = SLOT_BITS'(m_slot);
                m_next_t = e + m_reload;
                m_slot   = (m_slot == m_last) ? 0 : m_slot + 1;
            end
            if (bus.STB_I && bus.CMD_I == 2'd0) m_table[bus.ADR_I] = bus.DAT_I;
            if (bus.STB_I && bus.CMD_I == 2'd3)
                m_reload = ((bus.DAT_I == 8'd0) ? 1 : int'(bus.DAT_I)) << (DWELL_BITS - 8);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("ack", bus.ACK_O, m_ack);
        chk("stb", bus.STB_O, m_stb);
        chk("dat", bus.DAT_O, m_dat);
        chk("running", o_running, m_running);
        chk("slot", o_slot, m_oslot);
        chk("alive", o_alive, m_alive[ALIVE_BITS-1]);
        if (bus.STB_O === 1'b1) begin
            stb_t.push_back(e);
            stb_d.push_back(bus.DAT_O);
            stb_s.push_back(o_slot);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cmd(input logic [1:0] c, input logic [1:0] a, input logic [7:0] d);
        bus.STB_I = 1'b1;
        bus.CMD_I = c;
        bus.ADR_I = a;
        bus.DAT_I = d;
        step();
        bus.STB_I = 1'b0;
    endtask

    task automatic clear_log();
        stb_t.delete();
        stb_d.delete();
        stb_s.delete();
    endtask

    task automatic wait_model_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = m_stb;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_basic = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'hA5};
        exp_short = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        bus.STB_I = 1'b0;
        bus.CMD_I = 2'd0;
        bus.ADR_I = '0;
        bus.DAT_I = 8'd0;

        // Reset, then START with an empty table.
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        cmd(2'd1, 2'd0, 8'd0);
        step();
        chk("empty_start_stb", bus.STB_O, 1'b1);
        chk("empty_start_dat", bus.DAT_O, 8'h00);
        idle(25);
        cmd(2'd2, 2'd0, 8'd0);

        // Basic sequence over all four slots, 12-clock dwell.
        cmd(2'd0, 2'd0, 8'hA5);
        cmd(2'd0, 2'd1, 8'h3C);
        cmd(2'd0, 2'd2, 8'h0F);
        cmd(2'd0, 2'd3, 8'hF0);
        cmd(2'd3, 2'd0, 8'd3);
        clear_log();
        cmd(2'd1, 2'd3, 8'd0);
        k = e;
        idle(50);
        chk("basic_count", stb_t.size() >= 5, 1'b1);
        for (int i = 0; i < 5 && i < stb_t.size(); i++) begin
            chk("basic_time", stb_t[i] - k, 1 + 12 * i);
            chk("basic_data", stb_d[i], exp_basic[i]);
        end

        // Short loop over slots 0..1.
        clear_log();
        cmd(2'd1, 2'd1, 8'd0);
        idle(40);
        chk("short_count", stb_t.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < stb_t.size(); i++) begin
            chk("short_data", stb_d[i], exp_short[i]);
            chk("short_slot", stb_s[i], i % 2);
        end

        // DWELL 0 mid-dwell: current 12-clock dwell finishes, then 4-clock period.
        wait_model_strobe(found);
        chk("dwell_sync", found, 1'b1);
        p = e;
        idle(3);
        clear_log();
        cmd(2'd3, 2'd0, 8'd0);
        idle(20);
        chk("dwell_count", stb_t.size() >= 3, 1'b1);
        if (stb_t.size() >= 3) begin
            chk("dwell_old_period", stb_t[0] - p, 12);
            chk("dwell_new_period", stb_t[1] - stb_t[0], 4);
            chk("dwell_new_period2", stb_t[2] - stb_t[1], 4);
        end

        // STOP five clocks after a strobe, hold quiet, then restart.
        wait_model_strobe(found);
        chk("stop_sync", found, 1'b1);
        idle(4);
        cmd(2'd2, 2'd0, 8'd0);
        chk("stop_running", o_running, 1'b0);
        saved_dat = bus.DAT_O;
        clear_log();
        idle(100);
        chk("stop_quiet", stb_t.size(), 0);
        chk("stop_dat_hold", bus.DAT_O, saved_dat);
        cmd(2'd1, 2'd1, 8'd0);
        step();
        chk("restart_stb", bus.STB_O, 1'b1);
        chk("restart_dat", bus.DAT_O, 8'hA5);
        chk("restart_slot", o_slot, 2'd0);

        // WRITE to slot 0 on the very edge slot 0 is emitted.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_running && m_next_t == e + 1 && m_slot == 0) found = 1'b1;
            else step();
        end
        chk("coll_sync", found, 1'b1);
        cmd(2'd0, 2'd0, 8'h77);
        chk("coll_old", bus.DAT_O, 8'hA5);
        clear_log();
        idle(8);
        chk("coll_count", stb_t.size(), 2);
        if (stb_t.size() == 2) chk("coll_new", stb_d[1], 8'h77);

        // Reset pulse in the middle of a dwell.
        wait_model_strobe(found);
        idle(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_stb", bus.STB_O, 1'b0);
        chk("rst_running", o_running, 1'b0);
        chk("rst_dat", bus.DAT_O, 8'h00);
        clear_log();
        idle(30);
        chk("rst_quiet", stb_t.size(), 0);

        // Random command traffic against the model.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                logic [1:0] c;
                c = 2'($urandom_range(0, 3));
                cmd(c, 2'($urandom_range(0, 3)),
                    (c == 2'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom));
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/prewish5k_mask_scheduler.md
Name: prewish5k_mask_scheduler

Overview:
- Mask playlist scheduler that sits between the controller and the mentor's mask-load input (STB_I/DAT_I).
- Holds a small table of 8-bit blink masks, written by the controller through a command strobe.
- While running, it emits each mask to the mentor as a one-cycle strobe, in slot order, with a programmable dwell period between strobes.
- It replaces direct DIP-to-mentor loading with a sequenced pattern show.

Parameters:
- SLOT_BITS, 2, slot index width; table depth = 2**SLOT_BITS.
- DWELL_BITS, 24, dwell counter width; must be >= 9.
- DEFAULT_DWELL, 24'd12000000, dwell reload value after reset, in clocks.
- ALIVE_BITS, 22, width of the alive-blink counter.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  synchronous reset, active high.
- STB_I  in  1  command strobe, one cycle per command.
- CMD_I  in  2  command code, sampled with STB_I: 00 WRITE, 01 START, 10 STOP, 11 DWELL.
- ADR_I  in  SLOT_BITS  slot index for WRITE; last-slot index for START.
- DAT_I  in  8  mask for WRITE; dwell coarse value for DWELL.
- ACK_O  out  1  one-cycle command acknowledge.
- STB_O  out  1  one-cycle mask strobe to the mentor.
- DAT_O  out  8  mask to the mentor; valid while STB_O is high and held afterwards.
- o_running  out  1  high while the sequence is active.
- o_slot  out  SLOT_BITS  slot most recently emitted.
- o_alive  out  1  MSB of the free-running alive counter.

Behaviour:
- All outputs are registered.
- Reset values: ACK_O=0, STB_O=0, DAT_O=0, o_running=0, o_slot=0, o_alive=0, all table entries=0, dwell_reload=DEFAULT_DWELL, last=0, state=IDLE.
- Reset asserted mid-run: all outputs take reset values at the next edge; no further strobes.
- Command acceptance:
  - A command is sampled at edge k when STB_I=1.
  - ACK_O is high for exactly the cycle after edge k, for every command code.
  - Back-to-back strobes are each accepted, each with its own ACK.
- WRITE: table[ADR_I] <= DAT_I. Allowed while running; takes effect the next time that slot is emitted.
- WRITE collision: a WRITE to the slot being emitted on the same edge emits the old value (read before write).
- DWELL:
  - dwell_reload <= DAT_I << (DWELL_BITS-8).
  - DAT_I=0 is treated as 1.
  - Takes effect at the next reload; the dwell currently running is not altered.
- START:
  - last <= ADR_I, slot <= 0, o_running <= 1.
  - state -> EMIT, so STB_O rises at edge k+1 with DAT_O=table[0].
  - START while running restarts from slot 0 the same way.
- STOP:
  - state -> IDLE and o_running <= 0 at edge k+1.
  - No strobe at or after edge k+1; DAT_O and o_slot hold.
  - STOP while IDLE is acknowledged only.
- State machine:
  - IDLE: wait for START.
  - EMIT (1 cycle): STB_O=1, DAT_O=table[slot], o_slot=slot, cnt <= dwell_reload-2; next DWELL. If dwell_reload=1, go directly to EMIT again instead.
  - DWELL: cnt decrements each cycle. At cnt=0, slot <= (slot==last) ? 0 : slot+1, and next state is EMIT.
- Timing: consecutive STB_O rising edges are exactly dwell_reload clocks apart.
- Wrap-around: the sequence wraps from last to 0 indefinitely.
- last=0: slot 0 is emitted repeatedly.
- Counter width: cnt is DWELL_BITS wide, unsigned, no overflow possible.
- Priority: a command arriving in the same cycle as a DWELL expiry wins. START/STOP override the pending EMIT.
- Alive counter: free-running, increments every clock, cleared by reset.

Test Plan:
- Bench parameters: DWELL_BITS=10, ALIVE_BITS=4.
- Reset check: hold RST_I 3 cycles -> all outputs 0; a START with no writes emits DAT_O=8'h00 from slot 0.
- Basic sequence: WRITE slots 0..3 = A5,3C,0F,F0; DWELL DAT_I=3 (12 clocks); START ADR_I=3 at edge k -> STB_O pulses at k+1, k+13, k+25, k+37, k+49 with DAT_O A5,3C,0F,F0,A5; each pulse exactly 1 cycle wide; ACK_O high each command cycle+1.
- Short loop: START ADR_I=1 -> strobe data sequence A5,3C,A5,3C; o_slot follows 0,1,0,1.
- DWELL edge: DWELL DAT_I=0 -> period 4 clocks; DWELL while running changes the period only after the current dwell completes.
- Stop and restart: STOP 5 clocks after a strobe -> o_running=0 next cycle, no STB_O for 100 clocks, DAT_O holds; START again -> slot 0 emitted at k+1.
- Collisions and reset: WRITE slot 0 = 77 on the same edge slot 0 is emitted -> old value emitted, 77 on the next wrap; RST_I pulsed mid-DWELL -> STB_O, o_running, DAT_O=0 and no strobes until the next START.
